// File: rtl/cmd_sync_pkg.sv
// Shared widths and helpers for the Gc_clk125 command receiver.
package cmd_sync_pkg;

  localparam int unsigned QUAL_W = 4;
  localparam int unsigned GAP_W  = 4;

  typedef logic [QUAL_W-1:0] qual_cnt_t;
  typedef logic [GAP_W-1:0]  gap_cnt_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/cmd_sync_chan.sv
// One command channel: level synchroniser, re-arm flag and minimum-width
// qualifier producing a single-cycle accept strobe per high phase.
module cmd_sync_chan
  import cmd_sync_pkg::*;
#(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned QUAL_MIN = 2
) (
  input  logic Gc_clk125,
  input  logic Gc_rst,
  input  logic Gc_req_lvl,
  output logic acc
);

  logic [SYNC_STG-1:0] sync_q;
  logic [SYNC_STG-1:0] fill_q;
  qual_cnt_t           qual_q;
  logic                armed_q;
  logic                s_lvl;
  logic                sync_valid;

  assign s_lvl      = sync_q[SYNC_STG-1];
  assign sync_valid = fill_q[SYNC_STG-1];

  assign acc = armed_q & s_lvl & (qual_q == QUAL_W'(QUAL_MIN - 1));

  always_ff @(posedge Gc_clk125) begin
    if (Gc_rst) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], Gc_req_lvl};
      fill_q <= {fill_q[SYNC_STG-2:0], 1'b1};
    end
  end

  always_ff @(posedge Gc_clk125) begin
    if (Gc_rst) begin
      qual_q <= '0;
    end else if (!s_lvl) begin
      qual_q <= '0;
    end else if (qual_q < QUAL_W'(QUAL_MIN)) begin
      qual_q <= qual_q + 1'b1;
    end
  end

  // The chain reads 0 right after reset regardless of the input, so arming
  // waits until it has refilled with real samples; a level held high across
  // reset release must first be seen low.
  always_ff @(posedge Gc_clk125) begin
    if (Gc_rst) begin
      armed_q <= 1'b0;
    end else if (sync_valid) begin
      if (!s_lvl) begin
        armed_q <= 1'b1;
      end else if (acc) begin
        armed_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmd_pulse_sync_n.sv
// N-channel command receiver: per-channel sync/qualify, then either direct
// pulses or round-robin serialisation with inter-command gap and drop count.
module cmd_pulse_sync_n
  import cmd_sync_pkg::*;
#(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned QUAL_MIN = 2,
  parameter int unsigned SER      = 1,
  parameter int unsigned GAP_CYC  = 0,
  parameter int unsigned DROP_W   = 8,
  localparam int unsigned ID_W    = id_width(CH_NUM)
) (
  input  logic              Gc_clk125,
  input  logic              Gc_rst,
  input  logic [CH_NUM-1:0] Gc_req_lvl,
  output logic [CH_NUM-1:0] Gc_cmd_pulse,
  output logic              Gc_cmd_valid,
  output logic [ID_W-1:0]   Gc_cmd_id,
  output logic [CH_NUM-1:0] Gc_pend,
  output logic [DROP_W-1:0] Gc_drop_cnt
);

  logic [CH_NUM-1:0] acc;
  logic [CH_NUM-1:0] pulse_q;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
    cmd_sync_chan #(
      .SYNC_STG(SYNC_STG),
      .QUAL_MIN(QUAL_MIN)
    ) u_chan (
      .Gc_clk125 (Gc_clk125),
      .Gc_rst    (Gc_rst),
      .Gc_req_lvl(Gc_req_lvl[gi]),
      .acc       (acc[gi])
    );
  end

  if (SER != 0) begin : g_ser
    localparam int unsigned SUM_W = DROP_W + 5;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [CH_NUM-1:0] pend_q;
    logic [CH_NUM-1:0] gnt;
    logic [CH_NUM-1:0] drop_vec;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    int unsigned       cand;
    gap_cnt_t          gap_q;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_nxt;
    logic [SUM_W-1:0]  drop_add;
    logic [SUM_W-1:0]  drop_sum;

    // Search starts one past the last grant and wraps.
    always_comb begin
      gnt     = '0;
      gnt_idx = ptr_q;
      gnt_any = 1'b0;
      cand    = 0;
      if (gap_q == '0) begin
        for (int unsigned k = 1; k <= CH_NUM; k++) begin
          cand = 32'(ptr_q) + k;
          if (cand >= CH_NUM) cand = cand - CH_NUM;
          if (!gnt_any && pend_q[cand]) begin
            gnt_any   = 1'b1;
            gnt_idx   = ID_W'(cand);
            gnt[cand] = 1'b1;
          end
        end
      end
    end

    // An accept on a channel that is pending and not granted this cycle is lost.
    always_comb begin
      drop_vec = acc & pend_q & ~gnt;
      drop_add = '0;
      for (int unsigned j = 0; j < CH_NUM; j++) begin
        drop_add = drop_add + SUM_W'(drop_vec[j]);
      end
      drop_sum = SUM_W'(drop_q) + drop_add;
      drop_nxt = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge Gc_clk125) begin
      if (Gc_rst) begin
        pend_q  <= '0;
        pulse_q <= '0;
        ptr_q   <= ID_W'(CH_NUM - 1);
        gap_q   <= '0;
        drop_q  <= '0;
      end else begin
        pend_q  <= (pend_q & ~gnt) | acc;
        pulse_q <= gnt;
        drop_q  <= drop_nxt;
        if (gnt_any) begin
          ptr_q <= gnt_idx;
          gap_q <= GAP_W'(GAP_CYC);
        end else if (gap_q != '0) begin
          gap_q <= gap_q - 1'b1;
        end
      end
    end

    assign Gc_pend     = pend_q;
    assign Gc_drop_cnt = drop_q;
  end else begin : g_dir
    always_ff @(posedge Gc_clk125) begin
      if (Gc_rst) begin
        pulse_q <= '0;
      end else begin
        pulse_q <= acc;
      end
    end

    assign Gc_pend     = '0;
    assign Gc_drop_cnt = '0;
  end

  assign Gc_cmd_pulse = pulse_q;
  assign Gc_cmd_valid = |pulse_q;

  always_comb begin
    logic hit;
    hit       = 1'b0;
    Gc_cmd_id = '0;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (pulse_q[j] && !hit) begin
        hit       = 1'b1;
        Gc_cmd_id = ID_W'(j);
      end
    end
  end

endmodule

// File: tb/tb_cmd_pulse_sync_n.sv
// Directed bench for cmd_pulse_sync_n over four parameter sets; expected
// pulses are queued with their cycle and checked as the DUTs emit them.
module tb_cmd_pulse_sync_n;

  typedef struct {
    int          cyc;
    logic [15:0] vec;
  } ev_t;

  logic Gc_clk125 = 1'b0;
  logic Gc_rst    = 1'b1;
  int   cyc       = 0;
  int   errors    = 0;
  int   checks    = 0;

  always #4 Gc_clk125 = ~Gc_clk125;
  always @(posedge Gc_clk125) cyc <= cyc + 1;

  // u0: defaults (2 ch, serial, no gap)
  logic [1:0] r0 = '0, p0, pe0;
  logic       v0;
  logic [0:0] id0;
  logic [7:0] d0;
  // u1: 4 ch, serial, gap 2
  logic [3:0] r1 = '0, p1, pe1;
  logic       v1;
  logic [1:0] id1;
  logic [7:0] d1;
  // u2: 2 ch, serial, gap 15, 2-bit drop counter
  logic [1:0] r2 = '0, p2, pe2;
  logic       v2;
  logic [0:0] id2;
  logic [1:0] d2;
  // u3: 3 ch, direct pulses
  logic [2:0] r3 = '0, p3, pe3;
  logic       v3;
  logic [1:0] id3;
  logic [7:0] d3;

  cmd_pulse_sync_n #(.CH_NUM(2), .SER(1), .GAP_CYC(0)) u0 (
    .Gc_clk125(Gc_clk125), .Gc_rst(Gc_rst), .Gc_req_lvl(r0), .Gc_cmd_pulse(p0),
    .Gc_cmd_valid(v0), .Gc_cmd_id(id0), .Gc_pend(pe0), .Gc_drop_cnt(d0));

  cmd_pulse_sync_n #(.CH_NUM(4), .SER(1), .GAP_CYC(2)) u1 (
    .Gc_clk125(Gc_clk125), .Gc_rst(Gc_rst), .Gc_req_lvl(r1), .Gc_cmd_pulse(p1),
    .Gc_cmd_valid(v1), .Gc_cmd_id(id1), .Gc_pend(pe1), .Gc_drop_cnt(d1));

  cmd_pulse_sync_n #(.CH_NUM(2), .SER(1), .GAP_CYC(15), .DROP_W(2)) u2 (
    .Gc_clk125(Gc_clk125), .Gc_rst(Gc_rst), .Gc_req_lvl(r2), .Gc_cmd_pulse(p2),
    .Gc_cmd_valid(v2), .Gc_cmd_id(id2), .Gc_pend(pe2), .Gc_drop_cnt(d2));

  cmd_pulse_sync_n #(.CH_NUM(3), .SER(0)) u3 (
    .Gc_clk125(Gc_clk125), .Gc_rst(Gc_rst), .Gc_req_lvl(r3), .Gc_cmd_pulse(p3),
    .Gc_cmd_valid(v3), .Gc_cmd_id(id3), .Gc_pend(pe3), .Gc_drop_cnt(d3));

  ev_t q0[$], q1[$], q2[$], q3[$];
  ev_t e0, e1, e2, e3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lowidx(input logic [15:0] v);
    for (int unsigned i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic mon_chk(input string nm, input ev_t e, input logic [15:0] vec,
                         input logic vld, input logic [31:0] id);
    chk({nm, " pulse cycle"}, 32'(cyc), 32'(e.cyc));
    chk({nm, " pulse vec"}, 32'(vec), 32'(e.vec));
    chk({nm, " cmd_id"}, id, 32'(lowidx(e.vec)));
    chk({nm, " cmd_valid"}, 32'(vld), 32'd1);
  endtask

  always @(negedge Gc_clk125) if (p0 != '0 || v0) begin
    if (q0.size() == 0) chk("u0 spurious pulse", 32'({v0, p0}), 32'd0);
    else begin e0 = q0.pop_front(); mon_chk("u0", e0, 16'(p0), v0, 32'(id0)); end
  end
  always @(negedge Gc_clk125) if (p1 != '0 || v1) begin
    if (q1.size() == 0) chk("u1 spurious pulse", 32'({v1, p1}), 32'd0);
    else begin e1 = q1.pop_front(); mon_chk("u1", e1, 16'(p1), v1, 32'(id1)); end
  end
  always @(negedge Gc_clk125) if (p2 != '0 || v2) begin
    if (q2.size() == 0) chk("u2 spurious pulse", 32'({v2, p2}), 32'd0);
    else begin e2 = q2.pop_front(); mon_chk("u2", e2, 16'(p2), v2, 32'(id2)); end
  end
  always @(negedge Gc_clk125) if (p3 != '0 || v3) begin
    if (q3.size() == 0) chk("u3 spurious pulse", 32'({v3, p3}), 32'd0);
    else begin e3 = q3.pop_front(); mon_chk("u3", e3, 16'(p3), v3, 32'(id3)); end
  end

  task automatic expect_pulse(input int unsigned dut, input int at, input logic [15:0] vec);
    ev_t e;
    e.cyc = at;
    e.vec = vec;
    case (dut)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Move to just after the edge that makes cyc == t (no-op if already there).
  task automatic drive_at(input int t);
    while (cyc < t) begin
      @(posedge Gc_clk125);
      #1;
    end
  endtask

  // Move to the falling edge inside cycle t; t must be ahead of any earlier call.
  task automatic neg_at(input int t);
    while (cyc < t) begin
      @(posedge Gc_clk125);
      #1;
    end
    @(negedge Gc_clk125);
  endtask

  int drop_exp[7] = '{0, 0, 1, 2, 2, 3, 3};

  initial begin
    // Reset and idle state
    drive_at(3);
    Gc_rst = 1'b0;
    neg_at(4);
    chk("u0 reset pulse", 32'({v0, id0, p0}), 32'd0);
    chk("u0 reset pend/drop", 32'({pe0, d0}), 32'd0);
    chk("u1 reset pulse", 32'({v1, id1, p1}), 32'd0);
    chk("u1 reset pend/drop", 32'({pe1, d1}), 32'd0);
    chk("u2 reset pulse", 32'({v2, id2, p2}), 32'd0);
    chk("u2 reset pend/drop", 32'({pe2, d2}), 32'd0);
    chk("u3 reset pulse", 32'({v3, id3, p3}), 32'd0);
    chk("u3 reset pend/drop", 32'({pe3, d3}), 32'd0);

    // u0: single ch0 command, 6 cycles high
    expect_pulse(0, 15, 16'h0001);
    drive_at(10); r0 = 2'b01;
    neg_at(14);   chk("u0 ch0 pend", 32'(pe0), 32'h1);
    drive_at(16); r0 = 2'b00;
    neg_at(16);   chk("u0 pend cleared", 32'(pe0), 32'h0);
    chk("u0 drop zero", 32'(d0), 32'h0);

    // u0: 1-cycle glitch on ch1 is ignored, then a 3-cycle high is accepted
    drive_at(25); r0 = 2'b10;
    drive_at(26); r0 = 2'b00;
    neg_at(29);   chk("u0 glitch no pend a", 32'(pe0), 32'h0);
    neg_at(31);   chk("u0 glitch no pend b", 32'(pe0), 32'h0);
    expect_pulse(0, 40, 16'h0002);
    drive_at(35); r0 = 2'b10;
    drive_at(38); r0 = 2'b00;
    neg_at(39);   chk("u0 ch1 pend", 32'(pe0), 32'h2);
    neg_at(42);   chk("u0 queue drained", 32'(q0.size()), 32'd0);

    // u1: all four together, gap 2 -> grants 3 cycles apart in index order
    expect_pulse(1, 55, 16'h0001);
    expect_pulse(1, 58, 16'h0002);
    expect_pulse(1, 61, 16'h0004);
    expect_pulse(1, 64, 16'h0008);
    drive_at(50); r1 = 4'hF;
    drive_at(54); r1 = 4'h0;
    neg_at(54);   chk("u1 all pend", 32'(pe1), 32'hF);
    neg_at(56);   chk("u1 pend after ch0", 32'(pe1), 32'hE);
    // pointer now at 3: ch0 then ch2
    expect_pulse(1, 80, 16'h0001);
    expect_pulse(1, 83, 16'h0004);
    drive_at(75); r1 = 4'b0101;
    drive_at(79); r1 = 4'b0000;
    neg_at(79);   chk("u1 ch0+ch2 pend", 32'(pe1), 32'h5);
    neg_at(81);   chk("u1 ch2 waiting", 32'(pe1), 32'h4);
    neg_at(86);   chk("u1 queue drained", 32'(q1.size()), 32'd0);

    // u2: ch0 commands every 5 cycles against a 15-cycle gap; drops saturate at 3
    expect_pulse(2, 105, 16'h0001);
    expect_pulse(2, 121, 16'h0001);
    expect_pulse(2, 137, 16'h0001);
    for (int k = 0; k < 7; k++) begin
      drive_at(100 + 5 * k); r2 = 2'b01;
      drive_at(103 + 5 * k); r2 = 2'b00;
      neg_at(104 + 5 * k);
      chk($sformatf("u2 drop_cnt after cmd%0d", k), 32'(d2), 32'(drop_exp[k]));
    end
    neg_at(140);
    chk("u2 queue drained", 32'(q2.size()), 32'd0);
    chk("u2 pend cleared", 32'(pe2), 32'h0);
    chk("u2 drop saturated", 32'(d2), 32'h3);

    // u0: levels high across reset release give nothing until seen low
    drive_at(150); r0 = 2'b11; Gc_rst = 1'b1;
    drive_at(153); Gc_rst = 1'b0;
    neg_at(154);
    chk("u2 drop cleared by reset", 32'(d2), 32'h0);
    chk("u0 pend after reset", 32'(pe0), 32'h0);
    neg_at(162);  chk("u0 held high no pend", 32'(pe0), 32'h0);
    expect_pulse(0, 171, 16'h0001);
    expect_pulse(0, 172, 16'h0002);
    drive_at(165); r0 = 2'b00;
    drive_at(166); r0 = 2'b11;
    drive_at(180); r0 = 2'b00;
    neg_at(181);  chk("u0 rearm queue drained", 32'(q0.size()), 32'd0);

    // u3: direct mode, all three at once
    expect_pulse(3, 194, 16'h0007);
    drive_at(190); r3 = 3'b111;
    neg_at(194);
    chk("u3 pend always 0", 32'(pe3), 32'h0);
    chk("u3 drop always 0", 32'(d3), 32'h0);
    drive_at(197); r3 = 3'b000;
    // reset during qualification kills the command
    drive_at(205); r3 = 3'b111;
    drive_at(207); Gc_rst = 1'b1;
    drive_at(208); Gc_rst = 1'b0;
    neg_at(208);
    chk("u3 outputs after mid reset", 32'({v3, id3, p3}), 32'd0);
    neg_at(209);
    chk("u3 no pulse after mid reset", 32'({v3, id3, p3}), 32'd0);
    drive_at(220); r3 = 3'b000;

    neg_at(225);
    chk("u0 final queue", 32'(q0.size()), 32'd0);
    chk("u1 final queue", 32'(q1.size()), 32'd0);
    chk("u2 final queue", 32'(q2.size()), 32'd0);
    chk("u3 final queue", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
